// File: rtl/mp_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   LIMB_W  : width of one limb handled by the shared adder
//   state_t : sequencer FSM states
//   ovf_f   : signed overflow from operand and result sign bits
package mp_add_sequencer_pkg;

   localparam int unsigned LIMB_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Overflow when both addends share a sign that the result does not.
   function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/mp_add_sequencer_adder.sv
// 32-bit Ling adder (combinational).
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin modulo 2^32
//   cout : carry out of bit 31
module lingadder32_bit
   import mp_add_sequencer_pkg::*;
(
   input  logic [LIMB_W-1:0] a,
   input  logic [LIMB_W-1:0] b,
   input  logic              cin,
   output logic [LIMB_W-1:0] sum,
   output logic              cout
);

   logic [LIMB_W-1:0] g;
   logic [LIMB_W-1:0] t;
   logic [LIMB_W-1:0] p;
   logic              h_prev;
   logic              t_prev;
   logic              c_prev;
   logic              h_cur;

   assign g = a & b;
   assign t = a | b;
   assign p = a ^ b;

   // Ling pseudo-carry H_i = g_i | t_(i-1) & H_(i-1); real carry c_i = t_i & H_i.
   // Seeding H_(-1)=cin with t_(-1)=1 folds the carry-in into bit 0.
   always_comb begin
      sum    = '0;
      h_prev = cin;
      t_prev = 1'b1;
      c_prev = cin;
      h_cur  = 1'b0;
      for (int i = 0; i < int'(LIMB_W); i++) begin
         sum[i] = p[i] ^ c_prev;
         h_cur  = g[i] | (t_prev & h_prev);
         c_prev = t[i] & h_cur;
         h_prev = h_cur;
         t_prev = t[i];
      end
      cout = c_prev;
   end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams WORDS limbs, LSB first,
// through one shared 32-bit Ling adder with a registered inter-limb carry.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : operand handshake (in_a, in_b, in_cin, in_sub)
//   out_valid/out_ready       : result handshake (out_sum, out_cout, out_ovf)
//   busy                      : high while limbs are being processed
// in_ready follows out_ready combinationally in DONE so a new operation can
// be accepted in the same cycle the previous result is consumed.
module mp_add_sequencer
   import mp_add_sequencer_pkg::*;
#(
   parameter  int unsigned WORDS = 4,
   localparam int unsigned N     = LIMB_W * WORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_cin,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_cout,
   output logic         out_ovf,
   output logic         busy
);

   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t                        state_q;
   state_t                        state_d;
   logic [IDX_W-1:0]              idx_q;
   logic [WORDS-1:0][LIMB_W-1:0]  a_q;
   logic [WORDS-1:0][LIMB_W-1:0]  b_q;
   logic [WORDS-1:0][LIMB_W-1:0]  sum_q;
   logic                          carry_q;
   logic                          cout_q;
   logic                          ovf_q;

   logic                          accept;
   logic                          step;
   logic                          last_limb;
   logic [LIMB_W-1:0]             add_sum;
   logic                          add_cout;

   assign last_limb = (idx_q == IDX_W'(WORDS - 1));

   lingadder32_bit u_adder (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Next state and handshake decode.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      step     = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            step = 1'b1;
            if (last_limb) state_d = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_d = in_valid ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
      accept = in_valid && in_ready;
   end

   // State, operand latches, limb results and carry chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
            idx_q   <= '0;
         end else if (step) begin
            sum_q[idx_q] <= add_sum;
            carry_q      <= add_cout;
            idx_q        <= idx_q + IDX_W'(1);
            if (last_limb) begin
               cout_q <= add_cout;
               ovf_q  <= ovf_f(a_q[WORDS-1][LIMB_W-1], b_q[WORDS-1][LIMB_W-1],
                               add_sum[LIMB_W-1]);
            end
         end
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer (WORDS=4): directed cases from the
// test plan followed by a randomized regression against a big-integer model.
module tb_mp_add_sequencer;

   localparam int unsigned WORDS = 4;
   localparam int unsigned N     = 32 * WORDS;
   localparam int unsigned CW    = N + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mp_add_sequencer #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Integer-level reference: returns {ovf, cout, sum}.
   function automatic logic [CW-1:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic sub, input logic cin);
      logic [N:0]   full;
      logic [N-1:0] s;
      logic         c;
      logic         v;
      if (sub) begin
         s = a - b;
         c = (a >= b);
         v = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
      end else begin
         full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
         s = full[N-1:0];
         c = full[N];
         v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
      end
      return {v, c, s};
   endfunction

   // Present one beat while the DUT is idle; returns #1 after the accepting edge.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic cin);
      in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges from acceptance until out_valid, bounded.
   task automatic wait_result(input string tag);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, CW'(lat), CW'(WORDS));
   endtask

   task automatic check_out(input string tag, input logic [N-1:0] s, input logic c, input logic v);
      chk({tag, "_sum"},  CW'(out_sum),  CW'(s));
      chk({tag, "_cout"}, CW'(out_cout), CW'(c));
      chk({tag, "_ovf"},  CW'(out_ovf),  CW'(v));
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic sub, input logic cin,
                           input logic [N-1:0] s, input logic c, input logic v);
      issue(a, b, sub, cin);
      wait_result(tag);
      check_out(tag, s, c, v);
      consume();
   endtask

   initial begin
      logic [N-1:0]  ones;
      logic [N-1:0]  maxpos;
      logic [N-1:0]  minneg;
      logic [N-1:0]  held;
      logic [CW-1:0] exp_q[$];
      logic [CW-1:0] exp;
      int            sent;
      int            recv;
      int            cyc;
      logic          hold;

      ones   = '1;
      maxpos = {1'b0, {(N-1){1'b1}}};
      minneg = {1'b1, {(N-1){1'b0}}};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", CW'(out_valid), CW'(0));
      chk("rst_busy",      CW'(busy),      CW'(0));
      check_out("rst", '0, 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", CW'(in_ready), CW'(1));

      // Full-width carry ripple, with RUN-phase visibility checks.
      issue(ones, N'(1), 1'b0, 1'b0);
      chk("ripple_busy",     CW'(busy),     CW'(1));
      chk("ripple_in_ready", CW'(in_ready), CW'(0));
      wait_result("ripple");
      check_out("ripple", '0, 1'b1, 1'b0);
      consume();

      // Borrow and plain subtract.
      directed("borrow", '0, N'(1), 1'b1, 1'b0, ones, 1'b0, 1'b0);
      directed("sub5_3", N'(5), N'(3), 1'b1, 1'b1, N'(2), 1'b1, 1'b0);

      // Signed overflow and carry-in.
      directed("ovf_add", maxpos, N'(1), 1'b0, 1'b0, minneg, 1'b0, 1'b1);
      directed("cin_add", '0, '0, 1'b0, 1'b1, N'(1), 1'b0, 1'b0);

      // Backpressure then same-cycle consume-and-accept.
      issue(N'(10), N'(20), 1'b0, 1'b0);
      wait_result("bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", CW'(out_valid), CW'(1));
         chk("bp_sum",       CW'(out_sum),   CW'(30));
         chk("bp_in_ready",  CW'(in_ready),  CW'(0));
      end
      in_a = N'(100); in_b = N'(23); in_sub = 1'b0; in_cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("bp_ready_follows", CW'(in_ready), CW'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_valid_drop", CW'(out_valid), CW'(0));
      chk("bp_rerun_busy", CW'(busy),      CW'(1));
      wait_result("bp2");
      check_out("bp2", N'(123), 1'b0, 1'b0);
      consume();

      // Reset at limb index 2.
      issue(N'(1000), N'(1), 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_busy_before", CW'(busy), CW'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", CW'(out_valid), CW'(0));
      chk("midrst_busy",      CW'(busy),      CW'(0));
      chk("midrst_in_ready",  CW'(in_ready),  CW'(1));
      check_out("midrst", '0, 1'b0, 1'b0);
      directed("after_rst", N'(3), N'(4), 1'b0, 1'b0, N'(7), 1'b0, 1'b0);

      // Randomized regression with random backpressure.
      sent = 0; recv = 0; cyc = 0; hold = 1'b0;
      while ((sent < 1000 || exp_q.size() != 0) && cyc < 30000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!hold && sent < 1000 && $urandom_range(0, 3) != 0) begin
            in_a   = {$urandom, $urandom, $urandom, $urandom};
            in_b   = {$urandom, $urandom, $urandom, $urandom};
            in_sub = 1'($urandom_range(0, 1));
            in_cin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
               0: in_b = in_a;
               1: in_a = ones;
               2: in_b = ones;
               3: begin held = in_a; in_a = {held[N-1], {(N-1){~held[N-1]}}}; end
               default: ;
            endcase
            in_valid = 1'b1;
            hold = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            chk("rnd_no_extra", CW'(exp_q.size() != 0), CW'(1));
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               chk("rnd_result", {out_ovf, out_cout, out_sum}, exp);
               recv++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_a, in_b, in_sub, in_cin));
            sent++;
            hold = 1'b0;
         end
         @(posedge clk); #1;
         if (!hold) in_valid = 1'b0;
         cyc++;
      end
      out_ready = 1'b0;
      chk("rnd_sent",     CW'(sent),          CW'(1000));
      chk("rnd_recv",     CW'(recv),          CW'(1000));
      chk("rnd_drained",  CW'(exp_q.size()),  CW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
